// File: rtl/hi_lo_multdiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU take one radix-2 step per cycle; MTHI/MTLO write in one cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO written here, mult/div latched and launched
// RUN   | one shift-add (mult) or restoring shift-subtract (div) step per cycle
// FIXUP | sign correction, HI/LO writeback, done pulse
module hi_lo_multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   a_raw;
    logic               op_div;
    logic               res_neg;
    logic               dvd_neg;
    logic               div_zero;

    logic accept;
    logic mthi_wr;
    logic mtlo_wr;
    logic fixup;

    // Decode of the launch-time operation.
    logic             in_signed;
    logic             in_div;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    always_comb begin
        in_signed = (funct == FN_MULT) || (funct == FN_DIV);
        in_div    = (funct == FN_DIV) || (funct == FN_DIVU);
        a_abs     = (in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_abs     = (in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mthi_wr    = 1'b0;
        mtlo_wr    = 1'b0;
        fixup      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (funct)
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            accept     = 1'b1;
                            state_next = RUN;
                        end
                        FN_MTHI: mthi_wr = 1'b1;
                        FN_MTLO: mtlo_wr = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (counter == CW'(WIDTH - 1)) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                fixup      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div,
    // so both ops share one shift register.
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        if (op_div) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mult_sum, acc[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod_fix = res_neg ? -acc : acc;
        if (!op_div) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            // Divide by zero returns all-ones quotient and the untouched dividend.
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = dvd_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            res_lo = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            counter  <= '0;
            acc      <= '0;
            b_mag    <= '0;
            a_raw    <= '0;
            op_div   <= 1'b0;
            res_neg  <= 1'b0;
            dvd_neg  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= fixup;
            if (accept) begin
                counter  <= '0;
                acc      <= {{WIDTH{1'b0}}, a_abs};
                b_mag    <= b_abs;
                a_raw    <= operand_a;
                op_div   <= in_div;
                res_neg  <= in_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                dvd_neg  <= in_signed && operand_a[WIDTH-1];
                div_zero <= (operand_b == '0);
            end
            if (state == RUN) begin
                acc     <= acc_step;
                counter <= counter + CW'(1);
            end
            if (mthi_wr) begin
                hi <= operand_a;
            end
            if (mtlo_wr) begin
                lo <= operand_a;
            end
            if (fixup) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule
